// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector-side blocks:
// FSM state encoding and default geometry.
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_t;

    localparam int DEF_PAT_W   = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_GAP_CYC = 2;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left shifter feeding the transmitter's serial output from its MSB.
// Priority: load (new pattern) > reload (repeat of held pattern) > shift.
module seq_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         reload,
    input  logic [W-1:0] reload_val,
    input  logic         shift,
    output logic         msb
);

    logic [W-1:0] sh_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_reg <= '0;
        end else if (load) begin
            sh_reg <= load_val;
        end else if (reload) begin
            sh_reg <= reload_val;
        end else if (shift) begin
            sh_reg <= {sh_reg[W-2:0], 1'b0};
        end
    end

    assign msb = sh_reg[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first rep times with idle gaps.
// Optional macro SEQ_PATTERN_TX_PARITY_EN appends an even-parity bit to every frame.
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int PAT_W   = DEF_PAT_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_CYC = DEF_GAP_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done
);

    localparam int BC_W  = $clog2(PAT_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    tx_state_t        state_reg, state_next;
    logic [PAT_W-1:0] pat_reg, pat_next;
    logic [CNT_W-1:0] rem_reg, rem_next;
    logic [BC_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             par_reg, par_next;
    logic             dout_reg, dout_next;
    logic             dout_vld_reg, dout_vld_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic sh_load, sh_reload, sh_shift, sh_msb;
    logic frame_end;

    seq_shift_reg #(.W(PAT_W)) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load),
        .load_val   (pat_in),
        .reload     (sh_reload),
        .reload_val (pat_reg),
        .shift      (sh_shift),
        .msb        (sh_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            pat_reg      <= '0;
            rem_reg      <= '0;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            par_reg      <= 1'b0;
            dout_reg     <= 1'b0;
            dout_vld_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pat_reg      <= pat_next;
            rem_reg      <= rem_next;
            bit_cnt_reg  <= bit_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            par_reg      <= par_next;
            dout_reg     <= dout_next;
            dout_vld_reg <= dout_vld_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Outputs are the registered image of the current state's action, so the
    // first bit appears one cycle after the capture edge.
    always_comb begin
        state_next    = state_reg;
        pat_next      = pat_reg;
        rem_next      = rem_reg;
        bit_cnt_next  = bit_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        par_next      = par_reg;
        dout_next     = 1'b0;
        dout_vld_next = 1'b0;
        busy_next     = 1'b0;
        done_next     = 1'b0;
        sh_load       = 1'b0;
        sh_reload     = 1'b0;
        sh_shift      = 1'b0;
        frame_end     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && (rep != '0)) begin
                    pat_next     = pat_in;
                    rem_next     = rep;
                    bit_cnt_next = BIT_LAST;
                    par_next     = 1'b0;
                    sh_load      = 1'b1;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy_next     = 1'b1;
                dout_vld_next = 1'b1;
                if (par_reg) begin
                    dout_next = ^pat_reg;
                    frame_end = 1'b1;
                end else begin
                    dout_next    = sh_msb;
                    sh_shift     = 1'b1;
                    bit_cnt_next = bit_cnt_reg - BC_W'(1);
                    if (bit_cnt_reg == '0) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        par_next = 1'b1;
`else
                        frame_end = 1'b1;
`endif
                    end
                end
                // rem_reg is at least 1 here, so the decrement cannot underflow.
                if (frame_end) begin
                    par_next     = 1'b0;
                    rem_next     = rem_reg - CNT_W'(1);
                    bit_cnt_next = BIT_LAST;
                    sh_reload    = 1'b1;
                    if (rem_reg == CNT_W'(1)) begin
                        state_next = ST_DONE;
                    end else if (GAP_CYC > 0) begin
                        gap_cnt_next = GAP_LAST;
                        state_next   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                busy_next = 1'b1;
                if (gap_cnt_reg == '0) begin
                    state_next = ST_SHIFT;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                par_next   = 1'b0;
            end
        endcase
    end

    assign dout     = dout_reg;
    assign dout_vld = dout_vld_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. The transmit-side counterpart of the team's serial sequence detectors.
- Captures a PAT_W-bit pattern and a repeat count on a start pulse.
- Shifts the pattern out MSB-first, one bit per clk, with a per-bit valid strobe.
- Inserts GAP_CYC idle cycles between repeats.
- Pulses done after the final bit.
- Drives stimulus lines for detector FSMs and serial links on the same clock domain.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 8, repeat-count width
GAP_CYC, 2, idle cycles between consecutive patterns (0 = back-to-back)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  request; sampled only in IDLE
pat_in  in  PAT_W  pattern, captured when start is accepted
rep  in  CNT_W  number of pattern transmissions, captured with pat_in
dout  out  1  serial data; 0 when not transmitting
dout_vld  out  1  high exactly on cycles carrying a pattern/parity bit
busy  out  1  high in SHIFT and GAP
done  out  1  single-cycle pulse after last bit of last repeat

Behaviour:
- Reset (rst=1 at a clk edge), including mid-transfer: state=IDLE, dout=0, dout_vld=0, busy=0, done=0. Transfer is abandoned and no done is issued. rst has priority over all other inputs.
- All outputs are registered.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 and rep!=0: capture pat_in into the shift register and rep into rem_cnt; bit_cnt=PAT_W-1; go to SHIFT.
  - start=1 and rep=0: ignored, stay IDLE, no done.
- SHIFT:
  - Each cycle dout=current MSB, dout_vld=1, busy=1.
  - Register shifts left; bit_cnt decrements.
  - After the last bit, rem_cnt decrements:
    - rem_cnt reaches 0: go to DONE.
    - Else GAP_CYC>0: go to GAP.
    - Else (GAP_CYC=0): restart SHIFT with the original pattern (held in a separate pattern register), no idle cycle.
- GAP:
  - dout=0, dout_vld=0, busy=1 for exactly GAP_CYC cycles.
  - Then SHIFT with the original pattern.
- DONE: done=1, busy=0, dout_vld=0 for one cycle, then IDLE.
- Latency: start sampled at edge T puts the first bit on dout after edge T+1, i.e. in the cycle following start.
- Frame length: one frame is PAT_W valid cycles. A full transfer is rep*PAT_W + (rep-1)*GAP_CYC busy cycles, then 1 done cycle.
- start in SHIFT/GAP/DONE: ignored. pat_in/rep changes after capture have no effect.
- rep is unsigned. Max rep = 2^CNT_W-1 with no wrap. rem_cnt never underflows.
- Illegal state encoding: return to IDLE with all outputs 0.

Optional Feature:
Macro SEQ_PATTERN_TX_PARITY_EN.
- Defined: after each pattern's last bit, one extra cycle with dout = even parity (XOR of the pattern) and dout_vld=1. A frame becomes PAT_W+1 valid cycles, and GAP/DONE follow the parity bit.
- Undefined: no parity cycle; frame is PAT_W cycles.

Decomposition:
- Shared package: state encoding constants (IDLE, SHIFT, GAP, DONE) and the default PAT_W/CNT_W/GAP_CYC values, reused by the detector-side blocks.
- Natural sub-module: seq_shift_reg (loadable PAT_W-bit left shifter with reload-from-pattern input). The FSM and counters stay in the top module.

Test Plan:
- pat_in=4'b1001, rep=1, start pulse -> dout 1,0,0,1 with dout_vld=1 for 4 cycles starting the cycle after start; done=1 on the 5th cycle; busy low again.
- pat_in=4'b1001, rep=3, GAP_CYC=2 -> three 1001 frames separated by 2 cycles of dout=0/dout_vld=0; busy high for 16 cycles; single done pulse.
- GAP_CYC=0, pat_in=4'b1100, rep=2 -> 8 consecutive valid bits 11001100, then done.
- start with rep=0 -> no busy, no dout_vld, no done. Second start during busy with a different pat_in -> ignored; original stream completes unchanged.
- rst asserted on the 3rd bit of rep=2 transfer -> next cycle all outputs 0 and state IDLE; no done; a fresh start then transmits normally.
- With SEQ_PATTERN_TX_PARITY_EN, pat_in=4'b1011, rep=1 -> dout 1,0,1,1,1 (parity=1) over 5 valid cycles, then done.
